// File: rtl/fifo_2_axis_upsizer.sv
// Drains a FWFT FIFO of {user, last, data} words and packs RATIO words per wide
// AXI-Stream beat, with a registered output stage and an accepted-packet counter.
module fifo_2_axis_upsizer #(
  parameter int IN_WIDTH        = 32,
  parameter int RATIO           = 4,
  parameter int FIFO_DATA_WIDTH = IN_WIDTH + 2,
  parameter int AXIS_DATA_WIDTH = IN_WIDTH * RATIO,
  parameter int KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FIFO_DATA_WIDTH-1:0] i_fifo_data,
  input  logic                       i_fifo_not_empty,
  output logic                       o_fifo_r_stb,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      o_axis_tkeep,
  output logic                       o_axis_tuser,
  output logic                       o_axis_tlast,
  output logic                       o_axis_tvalid,
  input  logic                       i_axis_tready,
  output logic [COUNT_WIDTH-1:0]     o_pkt_count
);

  localparam int LANE_BYTES = IN_WIDTH / 8;
  localparam int IDX_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [AXIS_DATA_WIDTH-1:0] a_data;
  logic [KEEP_WIDTH-1:0]      a_keep;
  logic                       a_user;
  logic                       a_last;
  logic                       a_done;
  logic [IDX_W-1:0]           lane_idx;

  logic                xfer;
  logic                pop;
  logic [IN_WIDTH-1:0] w_data;
  logic                w_last;
  logic                w_user;

  assign w_data = i_fifo_data[IN_WIDTH-1:0];
  assign w_last = i_fifo_data[IN_WIDTH];
  assign w_user = i_fifo_data[IN_WIDTH+1];

  assign xfer = a_done & (~o_axis_tvalid | i_axis_tready);
  // rst_n gates the strobe so nothing is consumed while the datapath is held in reset
  assign pop  = rst_n & i_fifo_not_empty & (~a_done | xfer);
  assign o_fifo_r_stb = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data   <= '0;
      a_keep   <= '0;
      a_user   <= 1'b0;
      a_last   <= 1'b0;
      a_done   <= 1'b0;
      lane_idx <= '0;
    end else begin
      if (xfer) begin
        a_done <= 1'b0;
        a_data <= '0;
        a_keep <= '0;
      end
      // a pop in the transfer cycle lands in lane 0 and overrides the clear above
      if (pop) begin
        for (int k = 0; k < RATIO; k++) begin
          if (lane_idx == IDX_W'(k)) begin
            a_data[k*IN_WIDTH +: IN_WIDTH]     <= w_data;
            a_keep[k*LANE_BYTES +: LANE_BYTES] <= '1;
          end
        end
        if (lane_idx == '0) a_user <= w_user;
        if (lane_idx == LAST_IDX || w_last) begin
          a_done   <= 1'b1;
          a_last   <= w_last;
          lane_idx <= '0;
        end else begin
          lane_idx <= lane_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_axis_tvalid <= 1'b0;
      o_axis_tdata  <= '0;
      o_axis_tkeep  <= '0;
      o_axis_tuser  <= 1'b0;
      o_axis_tlast  <= 1'b0;
      o_pkt_count   <= '0;
    end else begin
      if (xfer) begin
        o_axis_tvalid <= 1'b1;
        o_axis_tdata  <= a_data;
        o_axis_tkeep  <= a_keep;
        o_axis_tuser  <= a_user;
        o_axis_tlast  <= a_last;
      end else if (o_axis_tvalid && i_axis_tready) begin
        o_axis_tvalid <= 1'b0;
      end
      if (o_axis_tvalid && i_axis_tready && o_axis_tlast) begin
        o_pkt_count <= o_pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_2_axis_upsizer.sv
// Scoreboard bench: a FIFO model feeds a RATIO=4 and a RATIO=1 instance; beats are
// predicted by grouping pushed words and compared by independent monitors.
module tb_fifo_2_axis_upsizer;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int FW = W + 2;
  localparam int AW = W * R;
  localparam int KW = AW / 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [FW-1:0] fifo_data = '0;
  logic          fifo_ne = 1'b0;
  logic          r_stb;
  logic [AW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tuser, tlast, tvalid;
  logic          tready = 1'b0;
  logic [CW-1:0] pkt_count;

  logic [FW-1:0] f1_data = '0;
  logic          f1_ne = 1'b0;
  logic          r1_stb;
  logic [W-1:0]  t1_data;
  logic [3:0]    t1_keep;
  logic          t1_user, t1_last, t1_valid;
  logic          t1_ready = 1'b0;
  logic [CW-1:0] pkt1;

  fifo_2_axis_upsizer #(.IN_WIDTH(W), .RATIO(R), .COUNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_fifo_data(fifo_data), .i_fifo_not_empty(fifo_ne), .o_fifo_r_stb(r_stb),
    .o_axis_tdata(tdata), .o_axis_tkeep(tkeep), .o_axis_tuser(tuser),
    .o_axis_tlast(tlast), .o_axis_tvalid(tvalid), .i_axis_tready(tready),
    .o_pkt_count(pkt_count)
  );

  fifo_2_axis_upsizer #(.IN_WIDTH(W), .RATIO(1), .COUNT_WIDTH(CW)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n),
    .i_fifo_data(f1_data), .i_fifo_not_empty(f1_ne), .o_fifo_r_stb(r1_stb),
    .o_axis_tdata(t1_data), .o_axis_tkeep(t1_keep), .o_axis_tuser(t1_user),
    .o_axis_tlast(t1_last), .o_axis_tvalid(t1_valid), .i_axis_tready(t1_ready),
    .o_pkt_count(pkt1)
  );

  typedef struct packed {
    logic [AW-1:0] data;
    logic [KW-1:0] keep;
    logic          user;
    logic          last;
  } beat_t;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] f1_q[$];
  beat_t         exp_q[$];
  logic [FW-1:0] exp1_q[$];
  beat_t         acc = '0;
  int            acc_n = 0;
  int            exp_pkt = 0;
  int            exp_pkt1 = 0;
  bit            stb_prev = 1'b0;
  bit            stb1_prev = 1'b0;
  int            rdy_mode = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: words are grouped into beats of R, or fewer when a word carries last.
  task automatic push_word(input logic [W-1:0] d, input logic last, input logic user);
    fifo_q.push_back({user, last, d});
    acc.data[acc_n*W +: W] = d;
    acc.keep[acc_n*4 +: 4] = 4'hF;
    if (acc_n == 0) acc.user = user;
    acc_n++;
    if (acc_n == R || last) begin
      acc.last = last;
      exp_q.push_back(acc);
      acc = '0;
      acc_n = 0;
    end
  endtask

  task automatic push_word1(input logic [W-1:0] d, input logic last, input logic user);
    f1_q.push_back({user, last, d});
    exp1_q.push_back({user, last, d});
  endtask

  // FIFO models: a strobe seen during a cycle consumes the head at the following edge.
  always begin
    @(negedge clk);
    if (stb_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_ne   = (fifo_q.size() > 0);
    fifo_data = fifo_ne ? fifo_q[0] : '0;
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom_range(0, 1));
    endcase
    #1 stb_prev = r_stb;
  end

  always begin
    @(negedge clk);
    if (stb1_prev && f1_q.size() > 0) void'(f1_q.pop_front());
    f1_ne    = (f1_q.size() > 0);
    f1_data  = f1_ne ? f1_q[0] : '0;
    t1_ready = ~t1_ready;
    #1 stb1_prev = r1_stb;
  end

  always begin : mon
    beat_t e;
    @(negedge clk);
    #2;
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected actual=%0h expected=none", tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 128'(tdata), 128'(e.data));
        check("tkeep", 128'(tkeep), 128'(e.keep));
        check("tuser", 128'(tuser), 128'(e.user));
        check("tlast", 128'(tlast), 128'(e.last));
        check("pkt_count", 128'(pkt_count), 128'(exp_pkt[CW-1:0]));
        if (e.last) exp_pkt++;
      end
    end
  end

  always begin : mon1
    logic [FW-1:0] e1;
    @(negedge clk);
    #2;
    if (t1_valid && t1_ready) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r1_unexpected actual=%0h expected=none", t1_data);
      end else begin
        e1 = exp1_q.pop_front();
        check("r1_word", 128'({t1_user, t1_last, t1_data}), 128'(e1));
        check("r1_tkeep", 128'(t1_keep), 128'(4'hF));
        check("r1_pkt_count", 128'(pkt1), 128'(exp_pkt1[CW-1:0]));
        if (e1[W]) exp_pkt1++;
      end
    end
  end

  task automatic wait_fifo_empty(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (fifo_q.size() == 0) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL fifo_drain_timeout actual=%0d expected=0", fifo_q.size());
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !tvalid &&
          f1_q.size() == 0 && exp1_q.size() == 0 && !t1_valid) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=%0d/%0d expected=0/0", exp_q.size(), exp1_q.size());
    end
  endtask

  initial begin
    logic [AW-1:0] snap_data;
    logic [KW-1:0] snap_keep;
    int gaps;

    repeat (3) @(negedge clk);
    #2;
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_tdata", 128'(tdata), 128'(0));
    check("rst_pkt_count", 128'(pkt_count), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // full beat closed by last on lane 3, latency from final pop
    @(negedge clk);
    #3;
    push_word(32'h11, 1'b0, 1'b0);
    push_word(32'h22, 1'b0, 1'b0);
    push_word(32'h33, 1'b0, 1'b0);
    push_word(32'h44, 1'b1, 1'b0);
    wait_fifo_empty(20);
    check("lat_tvalid_t1", 128'(tvalid), 128'(0));
    @(negedge clk);
    #2;
    check("lat_tvalid_t2", 128'(tvalid), 128'(1));
    check("lat_tdata", 128'(tdata), 128'h00000044_00000033_00000022_00000011);
    wait_idle(50);
    check("pkt_count_1", 128'(pkt_count), 128'(1));

    // partial beat
    @(negedge clk);
    #3;
    push_word(32'hA, 1'b0, 1'b0);
    push_word(32'hB, 1'b1, 1'b0);
    wait_idle(50);

    // backpressure: only two beats may be absorbed
    rdy_mode = 0;
    @(negedge clk);
    #3;
    for (int i = 0; i < 12; i++) push_word(32'h100 + 32'(i), 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    check("bp_fifo_left", 128'(fifo_q.size()), 128'(4));
    check("bp_tvalid", 128'(tvalid), 128'(1));
    snap_data = tdata;
    snap_keep = tkeep;
    repeat (3) @(negedge clk);
    #2;
    check("bp_tdata_stable", 128'(tdata), 128'(snap_data));
    check("bp_tkeep_stable", 128'(tkeep), 128'(snap_keep));
    check("bp_fifo_still", 128'(fifo_q.size()), 128'(4));
    rdy_mode = 1;
    wait_idle(100);

    // sustained stream: strobe must be high every cycle the FIFO has data
    @(negedge clk);
    #3;
    for (int i = 0; i < 64; i++) push_word($urandom, 1'b0, (i == 0));
    gaps = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (fifo_q.size() == 0) break;
      if (!r_stb) gaps++;
    end
    check("stream_gaps", 128'(gaps), 128'(0));
    wait_idle(100);

    // reset mid-beat discards the partial beat
    @(negedge clk);
    #3;
    push_word(32'h55, 1'b0, 1'b0);
    push_word(32'h66, 1'b0, 1'b0);
    wait_fifo_empty(20);
    @(negedge clk);
    #4 rst_n = 1'b0;
    acc = '0;
    acc_n = 0;
    exp_pkt = 0;
    exp_pkt1 = 0;
    #1;
    check("rst2_tvalid", 128'(tvalid), 128'(0));
    check("rst2_tkeep", 128'(tkeep), 128'(0));
    check("rst2_tuser_tlast", 128'({tuser, tlast}), 128'(0));
    check("rst2_pkt_count", 128'(pkt_count), 128'(0));
    push_word(32'h77, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    check("rst2_r_stb", 128'(r_stb), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_word(32'h88, 1'b0, 1'b0);
    push_word(32'h99, 1'b1, 1'b0);
    wait_idle(50);
    check("pkt_count_after_rst", 128'(pkt_count), 128'(1));

    // randomized traffic with random sink stalls
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        @(negedge clk);
        #3;
      end
      push_word($urandom, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end
    wait_idle(3000);
    rdy_mode = 1;

    // RATIO=1 pass-through with alternating tready
    @(negedge clk);
    #3;
    for (int i = 0; i < 20; i++) push_word1($urandom, (i % 5 == 4), 1'($urandom_range(0, 1)));
    wait_idle(200);
    check("r1_pkt_final", 128'(pkt1), 128'(4));

    check("pkt_count_final", 128'(pkt_count), 128'(exp_pkt[CW-1:0]));
    check("exp_q_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_2_axis_upsizer.md
Name: fifo_2_axis_upsizer

Overview:
- Drains a first-word-fall-through FIFO whose words carry {user, last, data}.
- Packs RATIO consecutive narrow words into one wide AXI-Stream beat, with a per-byte tkeep for partial beats.
- A word with last=1 closes the current beat early; the beat goes out with that beat's tlast set.
- Fully registered output stage, so it can drive a wide AXIS sink (DMA/PCIe) directly. Also counts completed packets.

Parameters:
- IN_WIDTH, 32, data bits per FIFO word; must be a multiple of 8.
- RATIO, 4, FIFO words per AXIS beat; must be ≥1. RATIO=1 degenerates to a registered pass-through.
- FIFO_DATA_WIDTH, IN_WIDTH+2, FIFO word width: bit [IN_WIDTH+1]=user, [IN_WIDTH]=last, [IN_WIDTH-1:0]=data.
- AXIS_DATA_WIDTH, IN_WIDTH*RATIO, derived output data width.
- KEEP_WIDTH, AXIS_DATA_WIDTH/8, derived tkeep width.
- COUNT_WIDTH, 16, width of the packet counter.

Ports:
- clk, input, 1, single clock for all logic.
- rst_n, input, 1, asynchronous active-low reset.
- i_fifo_data, input, FIFO_DATA_WIDTH, FWFT head word; valid while i_fifo_not_empty=1.
- i_fifo_not_empty, input, 1, FIFO has a word at its head.
- o_fifo_r_stb, output, 1, pop strobe; one word consumed per cycle high.
- o_axis_tdata, output, AXIS_DATA_WIDTH, packed beat; lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- o_axis_tkeep, output, KEEP_WIDTH, byte enables; all bytes of each filled lane are 1.
- o_axis_tuser, output, 1, user bit of lane 0 of the beat (start-of-frame marker).
- o_axis_tlast, output, 1, beat contains a word with last=1.
- o_axis_tvalid, output, 1, output register holds a beat.
- i_axis_tready, input, 1, sink accepts the beat.
- o_pkt_count, output, COUNT_WIDTH, number of tlast beats accepted since reset; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset: clk and rst_n (asynchronous, active-low) are already decided. While rst_n=0:
  - o_axis_tvalid, tdata, tkeep, tuser, tlast are all 0; o_pkt_count=0.
  - Internal lane index, assembly register and done flag are cleared.
  - o_fifo_r_stb is forced 0.
  - Reset mid-beat discards the partial beat; no words are popped until reset deasserts.
- Storage: assembly register A (lanes, keep, user, last, lane_idx, a_done) plus output register O.
- Transfer: xfer = a_done & (!o_axis_tvalid | i_axis_tready).
  - On xfer, O<=A and a_done<=0.
  - A's data and keep are cleared, except when the same cycle also pops a word into lane 0.
- Pop: o_fifo_r_stb = i_fifo_not_empty & (!a_done | xfer). The combinational path from i_axis_tready is permitted.
- On each pop:
  - data is written to lane lane_idx and that lane's keep bytes are set.
  - user is captured only when lane_idx=0.
  - If lane_idx=RATIO-1 or the word's last=1: a_done<=1, lane_idx<=0, A.last<=word.last.
  - Otherwise lane_idx increments.
- Unfilled lanes: tdata=0 and keep=0. Partial beats occur only when a beat is closed by last.
- Output handshake:
  - When o_axis_tvalid & i_axis_tready and no xfer: o_axis_tvalid<=0.
  - While tvalid=1 and tready=0, all o_axis_* signals are held stable.
  - AXIS rule: tvalid never depends combinationally on tready.
- Latency: the pop completing a beat at cycle t gives a_done at t+1 and o_axis_tvalid at t+2 (output idle, sink ready).
- Throughput:
  - RATIO≥2: one pop per cycle sustained while the sink is ready.
  - RATIO=1: one beat per cycle sustained with tready=1.
- Backpressure: with tready=0, at most one beat is in O and one completed beat in A; then popping stops.
- Packet count: o_pkt_count increments on every accepted beat with tlast=1.
- Empty FIFO mid-beat: the partial beat waits in A indefinitely. There is no timeout flush.

Test Plan:
- IN_WIDTH=32, RATIO=4; push words 0x11,0x22,0x33,0x44 (last on 0x44), tready=1 -> one beat tdata=0x00000044_00000033_00000022_00000011, tkeep=0xFFFF, tlast=1, tvalid at pop+2, o_pkt_count=1.
- Push 0xA,0xB with last on 0xB -> tdata upper 64 bits = 0, tkeep=0x00FF, tlast=1.
- Push 8 words, no last; tready low for 10 cycles -> tdata/tkeep stable; popping stops after 8 words. Raise tready -> 2 beats in order, no loss or duplication.
- Continuous 64-word stream with user=1 on word 0 only, tready=1 -> 16 beats with r_stb high every cycle; tuser=1 only on beat 0.
- rst_n pulsed low after 2 words of a beat -> all outputs 0 asynchronously, r_stb=0 during reset. The next packet starts cleanly at lane 0 with no stale bytes.
- RATIO=1; alternate tready 1/0 over 20 words -> each word appears once in order, tkeep=0xF, pass-through behaviour.
